// File: rtl/mem_access_host_pkg.sv
// Shared definitions for the UART memory-access host: command codes, frame lengths,
// FSM state encoding and the read-range validity check.
package mem_access_host_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0F;
  localparam logic [7:0] CMD_READ       = 8'hFF;
  // Index of the last byte in each frame (frame length minus one).
  localparam logic [2:0] WR_FRAME_BYTES = 3'd7;
  localparam logic [2:0] RD_FRAME_BYTES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2,
    ST_RECV = 2'd3
  } state_e;

  // A read range must be word aligned at both ends and non-empty.
  function automatic logic rd_reject(input logic [15:0] lo, input logic [15:0] hi);
    return (lo[1:0] != 2'b00) || (hi[1:0] != 2'b00) || (hi < lo);
  endfunction

endpackage

// File: rtl/mem_access_host.sv
// Host-side initiator for the UART memory-access protocol: serialises write/read command
// frames to a UART TX and reassembles read data from a UART RX into 32-bit words.
module mem_access_host
  import mem_access_host_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 1000000,
  parameter int TO_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_hi,
  input  logic [3:0]            cmd_wstrb,
  input  logic [31:0]           cmd_wdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  byte_done,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_last,
  output logic                  done,
  output logic                  err
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [15:0]           lo_q, lo_d;
  logic [15:0]           hi_q, hi_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            idx_q, idx_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [14:0]           wcnt_q, wcnt_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0]            frame_byte;
  logic [2:0]            last_idx;
  logic [15:0]           span;
  logic [14:0]           nwords;

  assign cmd_ready = (state_q == ST_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign done      = done_q;
  assign err       = err_q;

  assign last_idx = we_q ? WR_FRAME_BYTES : RD_FRAME_BYTES;
  assign span     = hi_q - lo_q;
  assign nwords   = 15'(span >> 2) + 15'd1;

  // Frame byte selected from the latched command by position in the frame.
  always_comb begin
    frame_byte = 8'h00;
    if (we_q) begin
      case (idx_q)
        3'd0:    frame_byte = CMD_WRITE;
        3'd1:    frame_byte = lo_q[7:0];
        3'd2:    frame_byte = lo_q[15:8];
        3'd3:    frame_byte = {4'h0, wstrb_q};
        3'd4:    frame_byte = wdata_q[7:0];
        3'd5:    frame_byte = wdata_q[15:8];
        3'd6:    frame_byte = wdata_q[23:16];
        default: frame_byte = wdata_q[31:24];
      endcase
    end else begin
      case (idx_q)
        3'd0:    frame_byte = CMD_READ;
        3'd1:    frame_byte = hi_q[7:0];
        3'd2:    frame_byte = hi_q[15:8];
        3'd3:    frame_byte = lo_q[7:0];
        default: frame_byte = lo_q[15:8];
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    to_d        = to_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d       = cmd_we;
          lo_d       = 16'(cmd_addr);
          hi_d       = 16'(cmd_addr_hi);
          wstrb_d    = cmd_wstrb;
          wdata_d    = cmd_wdata;
          idx_d      = 3'd0;
          tx_valid_d = 1'b0;
          if (!cmd_we && rd_reject(16'(cmd_addr), 16'(cmd_addr_hi))) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      // One idle cycle between bytes: present, wait for handshake, drop, repeat.
      ST_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q == last_idx) begin
            if (we_q) begin
              done_d  = 1'b1;
              state_d = ST_FIN;
            end else begin
              wcnt_d  = nwords;
              bcnt_d  = 2'd0;
              to_d    = '0;
              state_d = ST_RECV;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      // A byte arriving in the cycle the timeout would fire takes priority.
      ST_RECV: begin
        if (byte_done) begin
          to_d       = '0;
          rsp_data_d = {rx_data, rsp_data_q[31:8]};
          bcnt_d     = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            rsp_valid_d = 1'b1;
            wcnt_d      = wcnt_q - 15'd1;
            if (wcnt_q == 15'd1) begin
              rsp_last_d = 1'b1;
              done_d     = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end else if (to_q == TO_WIDTH'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      to_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      to_q        <= to_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_host.sv
// Bench for mem_access_host: the bench plays the UART slave with a word memory model,
// checks emitted frames, returned words, pulse timing, rejects and the read timeout.
module tb_mem_access_host;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr, cmd_addr_hi;
  logic [3:0]  cmd_wstrb;
  logic [31:0] cmd_wdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        byte_done;
  logic        rsp_valid, rsp_last, done, err;
  logic [31:0] rsp_data;

  mem_access_host #(.ADDR_WIDTH(16), .TIMEOUT(TO), .TO_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_addr_hi(cmd_addr_hi),
    .cmd_wstrb(cmd_wstrb), .cmd_wdata(cmd_wdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .byte_done(byte_done),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tx_q[$];
  logic [32:0] rsp_q[$];
  int done_cnt = 0, err_cnt = 0;
  int last_tx_cyc = 0, done_cyc = 0, err_cyc = 0, last_rx_cyc = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  int rdy_mode   = 0;
  int stall_left = 0;
  logic [31:0] mem [0:16383];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Observes the DUT on the falling edge, halfway between active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
        chk("tx_hold_data", {24'b0, tx_data}, {24'b0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        last_tx_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (rsp_valid) rsp_q.push_back({rsp_last, rsp_data});
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
      if (byte_done) last_rx_cyc = cyc;
    end
  end

  // UART TX readiness: always ready, random, or a forced stall after the third byte.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (stall_left > 0 && tx_q.size() == 3) begin
        tx_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) begin
        tx_ready = 1'($urandom_range(0, 1));
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic run_cmd(input bit we, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [3:0] ws, input logic [31:0] wd, input int nret);
    int d0, e0, to, nw;
    bit rej;
    logic [7:0] ef[$];
    logic [31:0] w;
    tx_q.delete();
    rsp_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    to = 0;
    while (!cmd_ready && to < 100) begin step(); to++; end
    chk("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = lo; cmd_addr_hi = hi;
    cmd_wstrb = ws; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
    rej = !we && ((lo % 4) != 0 || (hi % 4) != 0 || hi < lo);
    if (rej) begin
      repeat (4) step();
      chk("rej_err", err_cnt - e0, 1);
      chk("rej_tx", tx_q.size(), 0);
      chk("rej_done", done_cnt - d0, 0);
      return;
    end
    if (we) ef = '{8'h0F, lo[7:0], lo[15:8], {4'h0, ws}, wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    else    ef = '{8'hFF, hi[7:0], hi[15:8], lo[7:0], lo[15:8]};
    to = 0;
    while (tx_q.size() < ef.size() && to < 400) begin step(); to++; end
    chk("tx_count", tx_q.size(), ef.size());
    for (int i = 0; i < ef.size() && i < tx_q.size(); i++)
      chk($sformatf("tx_byte%0d", i), {24'b0, tx_q[i]}, {24'b0, ef[i]});
    if (we) begin
      repeat (3) step();
      chk("wr_done", done_cnt - d0, 1);
      chk("wr_done_cyc", done_cyc, last_tx_cyc + 1);
      chk("wr_tx_after", tx_q.size(), 8);
      for (int b = 0; b < 4; b++)
        if (ws[b]) mem[lo >> 2][8*b +: 8] = wd[8*b +: 8];
      return;
    end
    nw = (int'(hi) - int'(lo)) / 4 + 1;
    for (int k = 0; k < nret; k++) begin
      repeat ($urandom_range(0, 4)) step();
      w = mem[(lo >> 2) + k / 4];
      rx_data   = w[8*(k%4) +: 8];
      byte_done = 1'b1;
      step();
      byte_done = 1'b0;
    end
    to = 0;
    while (done_cnt == d0 && err_cnt == e0 && to < TO + 50) begin step(); to++; end
    repeat (2) step();
    if (nret == 4 * nw) begin
      chk("rd_done", done_cnt - d0, 1);
      chk("rd_err", err_cnt - e0, 0);
      chk("rd_nrsp", rsp_q.size(), nw);
      for (int i = 0; i < nw && i < rsp_q.size(); i++) begin
        chk($sformatf("rd_data%0d", i), rsp_q[i][31:0], mem[(lo >> 2) + i]);
        chk($sformatf("rd_last%0d", i), {31'b0, rsp_q[i][32]}, (i == nw - 1) ? 32'd1 : 32'd0);
      end
    end else begin
      chk("to_err", err_cnt - e0, 1);
      chk("to_done", done_cnt - d0, 0);
      chk("to_nrsp", rsp_q.size(), nret / 4);
      chk("to_interval", err_cyc - last_rx_cyc - 1, TO);
    end
  endtask

  initial begin
    int to;
    logic [15:0] base, lo, hi;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_addr_hi = '0;
    cmd_wstrb = '0; cmd_wdata = '0; rx_data = '0; byte_done = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    repeat (3) step();
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", {31'b0, rsp_last}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    rst_n = 1'b1;
    step();

    run_cmd(1'b1, 16'h0010, 16'h0000, 4'hF, 32'hDEADBEEF, 0);
    chk("mem_after_wr", mem[4], 32'hDEADBEEF);

    // Unsolicited RX byte while idle must not disturb the next read.
    rx_data = 8'hAA; byte_done = 1'b1; step(); byte_done = 1'b0; step();

    mem[8] = 32'h12345678;
    run_cmd(1'b0, 16'h0020, 16'h0020, 4'h0, 32'h0, 4);
    run_cmd(1'b0, 16'h0000, 16'h0008, 4'h0, 32'h0, 12);

    stall_left = 10;
    run_cmd(1'b1, 16'h0104, 16'h0000, 4'h5, $urandom, 0);
    chk("stall_used", stall_left, 0);

    run_cmd(1'b0, 16'h0002, 16'h0010, 4'h0, 32'h0, 0);
    run_cmd(1'b0, 16'h0010, 16'h000C, 4'h0, 32'h0, 0);
    run_cmd(1'b0, 16'h0010, 16'h0012, 4'h0, 32'h0, 0);
    run_cmd(1'b0, 16'h0040, 16'h0040, 4'h0, 32'h0, 2);
    run_cmd(1'b0, 16'h0040, 16'h0044, 4'h0, 32'h0, 6);
    run_cmd(1'b0, 16'hFFF0, 16'hFFFC, 4'h0, 32'h0, 16);

    // Reset in the middle of a write frame.
    rdy_mode = 1;
    tx_q.delete();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0200; cmd_wstrb = 4'hF; cmd_wdata = $urandom;
    step();
    cmd_valid = 1'b0;
    to = 0;
    while (tx_q.size() < 3 && to < 200) begin step(); to++; end
    chk("midsend_progress", tx_q.size(), 3);
    rst_n = 1'b0;
    step();
    chk("midsend_tx_valid", {31'b0, tx_valid}, 0);
    chk("midsend_cmd_ready", {31'b0, cmd_ready}, 1);
    rst_n = 1'b1;
    step();

    // Loopback: random writes then random range read-backs through the memory model.
    for (int r = 0; r < 4; r++) begin
      base = 16'($urandom_range(0, 16379)) << 2;
      for (int i = 0; i < 4; i++)
        run_cmd(1'b1, base + 16'(4 * i), 16'h0000, 4'($urandom_range(1, 15)), $urandom, 0);
      run_cmd(1'b0, base, base + 16'd12, 4'h0, 32'h0, 16);
      lo = 16'($urandom_range(0, 16370)) << 2;
      hi = lo + (16'($urandom_range(0, 7)) << 2);
      run_cmd(1'b0, lo, hi, 4'h0, 32'h0, 4 * ((int'(hi) - int'(lo)) / 4 + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
